// File: rtl/frame_stream_if.sv
// AXI-Stream pixel channel between the frame reader and the convolution datapath.
// A beat transfers on a rising edge where tvalid && tready. Once tvalid is high the payload holds until that handshake.
interface frame_stream_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/frame_stream_reader.sv
// Reads one IMG_W x IMG_H frame from a 1-cycle-latency BRAM and streams it out as AXI-Stream.
// tuser marks pixel 0 and tlast marks the final pixel.
module frame_stream_reader #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rdata,
    frame_stream_if.master    m_axis,
    output logic [0:0]        state_dbg
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              user;
    } beat_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic              all_issued_q;
    logic              inflight_q;
    logic              tag_last_q;
    logic              tag_user_q;
    logic              done_q;

    beat_t             fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    beat_t             head;
    logic              tvalid;
    logic              pop;
    logic              push;
    logic [1:0]        occ;
    logic              issue;
    logic              accept;
    logic              last_hs;

    // Occupancy counts the read still in flight so the 2-entry buffer can never overflow.
    always_comb begin
        head    = fifo_q[rd_ptr_q];
        tvalid  = (count_q != 2'd0);
        pop     = tvalid && m_axis.tready;
        push    = inflight_q;
        occ     = count_q + {1'b0, inflight_q};
        accept  = (state_q == S_IDLE) && start;
        last_hs = pop && head.last;
        issue   = (state_q == S_STREAM) && !all_issued_q &&
                  ((occ < 2'd2) || ((occ == 2'd2) && pop));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)  state_d = S_STREAM;
            S_STREAM: if (last_hs) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            rd_idx_q     <= '0;
            all_issued_q <= 1'b0;
            inflight_q   <= 1'b0;
            tag_last_q   <= 1'b0;
            tag_user_q   <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_STREAM) && last_hs;

            if (accept) begin
                base_q       <= base_addr;
                rd_idx_q     <= '0;
                all_issued_q <= 1'b0;
            end else if (issue) begin
                if (rd_idx_q == LAST_IDX) begin
                    all_issued_q <= 1'b1;
                end else begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                end
            end

            // Frame markers are decided at issue time and ride along with the read.
            inflight_q <= issue;
            if (issue) begin
                tag_last_q <= (rd_idx_q == LAST_IDX);
                tag_user_q <= (rd_idx_q == '0);
            end

            if (push) begin
                fifo_q[wr_ptr_q] <= '{data: bram_rdata, last: tag_last_q, user: tag_user_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        busy          = (state_q == S_STREAM);
        done          = done_q;
        bram_en       = issue;
        bram_addr     = issue ? (base_q + ADDR_W'(rd_idx_q)) : '0;
        m_axis.tvalid = tvalid;
        m_axis.tdata  = tvalid ? head.data : '0;
        m_axis.tlast  = tvalid && head.last;
        m_axis.tuser  = tvalid && head.user;
        state_dbg     = state_q;
    end
endmodule

// File: doc/frame_stream_reader.md
# frame_stream_reader

Streaming pixel source for the convolution datapath: on a start pulse it reads one IMG_W×IMG_H frame of 16-bit pixels from an on-chip frame BRAM (synchronous read, 1-cycle latency) and transmits it as an AXI-Stream master. Its master port connects directly to the convolution block's slave pixel input, replacing the DMA in on-chip test and loopback configurations. It honours full AXI-Stream backpressure without losing or duplicating pixels, marks start-of-frame on tuser and end-of-frame on tlast, and sustains one pixel per cycle while tready stays high.

## Interface
- DATA_W, 16, pixel width
- IMG_W, 128, pixels per row
- IMG_H, 128, rows per frame
- ADDR_W, 14, BRAM address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- start  in  1  frame request; sampled only in IDLE
- base_addr  in  ADDR_W  BRAM address of pixel 0; captured when start is accepted
- busy  out  1  high from the cycle after start is accepted through the last-beat handshake cycle
- done  out  1  one-cycle pulse the cycle after the last-beat handshake
- bram_en  out  1  read enable
- bram_addr  out  ADDR_W  read address
- bram_rdata  in  DATA_W  read data, valid the cycle after bram_en=1
- m_axis_tdata  out  DATA_W  pixel
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on pixel IMG_W·IMG_H−1 only
- m_axis_tuser  out  1  high on pixel 0 only (start of frame)

## Operation
- FSM: IDLE → STREAM on start=1; STREAM → IDLE after the handshake of the last beat (tvalid && tready && tlast); done pulses on that transition.
- Issue counter rd_idx (0..IMG_W·IMG_H−1): read address = base_addr + rd_idx, modulo 2^ADDR_W (wraps silently).
- Output buffer: 2-entry FIFO of {tdata, tlast, tuser}; head drives m_axis_*. tlast/tuser are computed from rd_idx at issue time and travel with the read.
- inflight flag: set the cycle bram_en=1, data pushed into the FIFO at the following edge.
- Read issue rule in STREAM while reads remain: bram_en=1 iff (count + inflight) < 2, or (count + inflight) = 2 and a pop occurs this cycle. Guarantees FIFO never overflows and no BRAM read is ever repeated.
- Pop = m_axis_tvalid && m_axis_tready. m_axis_tvalid = (count ≠ 0).
- After the final read is issued, bram_en stays 0; the FSM remains in STREAM until the FIFO drains.
- start while busy: ignored; base_addr changes while busy: ignored.
- Frame counting internal only; no row/col outputs.

## Timing
- Reset (aresetn=0 at an edge): state IDLE, FIFO and inflight cleared, rd_idx=0; all outputs 0 (busy, done, bram_en, bram_addr, tdata, tvalid, tlast, tuser). Reset mid-frame abandons the frame; the returning in-flight read data is discarded.
- start accepted in cycle C: bram_en=1, bram_addr=base_addr in C+1; rdata valid in C+2 and pushed at end of C+2; first beat (tuser=1) tvalid in C+3. Start-to-first-beat latency: 3 cycles.
- tready held high: beat k presented in cycle C+3+k; last beat in C+2+IMG_W·IMG_H; done in C+3+IMG_W·IMG_H; new start accepted from that cycle on.
- AXI stability: while tvalid=1 and tready=0, tdata/tlast/tuser/tvalid hold unchanged. tvalid never drops without a handshake.
- tready low for N cycles: at most 2 beats buffered, bram_en=0 after the buffer plus inflight reaches 2; on tready rising, beats resume the same cycle with no bubble.
- Simultaneous push and pop: count unchanged; simultaneous push into full FIFO cannot occur by the issue rule.

## Test plan
- Reset/idle: hold aresetn=0 5 cycles, then start=0 → all outputs 0, no bram_en for 20 cycles.
- Full frame, tready=1, base_addr=0, BRAM[i]=i → 16384 beats, data 0..16383 in order, tuser only on beat 0, tlast only on beat 16383, first tvalid 3 cycles after start, done exactly 1 cycle after last beat, zero bubbles.
- Random backpressure (tready 50% random), IMG_W=IMG_H=4 → exactly 16 beats, no loss/duplication, payload stable during every stall, each BRAM address read once.
- Wrap: ADDR_W=4, IMG_W=IMG_H=4, base_addr=12 → addresses 12,13,14,15,0,…,11.
- Start during busy with different base_addr → ignored, frame completes from original base; start at done cycle → second frame starts, first tvalid 3 cycles later.
- Reset asserted mid-frame with tready=0 → all outputs 0 next cycle; later start streams a clean frame beginning with tuser=1, pixel base_addr.
